memory_stage_hs: RTL and testbench

//  Pipeline MEM stage directly downstream of the execute stage. It consumes the E/M register outputs and runs
//  a load/store over a valid/ready data-memory handshake. While the memory waits it stalls the upstream

---
 rtl/mem_stage_pkg.sv | 12 +
 rtl/dmem_hs_fsm.sv | 60 ++++++
 rtl/memory_stage_hs.sv | 101 ++++++++++
 tb/tb_memory_stage_hs.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the MEM pipeline stage
package mem_stage_pkg;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } ms_state_t;

  localparam logic RESULT_ALU = 1'b0;
  localparam logic RESULT_MEM = 1'b1;

endpackage

// File: rtl/dmem_hs_fsm.sv
// rtl/dmem_hs_fsm.sv - data-memory valid/ready handshake sequencer with wait timeout
module dmem_hs_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic dmem_ready,
  output logic in_idle,
  output logic req,
  output logic stall,
  output logic complete,
  output logic abort
);

  ms_state_t        state;
  logic [CNT_W-1:0] wait_cnt;
  logic             at_limit;

  assign at_limit = (wait_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= MS_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        MS_IDLE: begin
          if (issue && !dmem_ready) begin
            state    <= MS_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        MS_WAIT: begin
          // a late ready wins over the timeout in the same cycle
          if (dmem_ready || at_limit) begin
            state    <= MS_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= MS_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign in_idle  = (state == MS_IDLE);
  assign req      = rst & (in_idle ? issue : 1'b1);
  assign stall    = rst & (in_idle ? (issue & ~dmem_ready) : (~dmem_ready & ~at_limit));
  assign complete = req & dmem_ready;
  assign abort    = rst & ~in_idle & ~dmem_ready & at_limit;

endmodule

// File: rtl/memory_stage_hs.sv
// rtl/memory_stage_hs.sv - MEM stage: load/store over a valid/ready data-memory port
// with upstream stall, M/W register bubble insertion and a sticky fault flag.
module memory_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [4:0]        RD_M,
  input  logic [DATA_W-1:0] PCPlus4M,
  input  logic [DATA_W-1:0] ALU_ResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic              StallM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [4:0]        RD_W,
  output logic [DATA_W-1:0] PCPlus4W,
  output logic [DATA_W-1:0] ALU_ResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic              mem_fault
);

  logic access;
  logic misaligned;
  logic issue;
  logic in_idle;
  logic fsm_stall;
  logic complete;
  logic abort;
  logic fault_now;

  assign access     = MemWriteM | (ResultSrcM == RESULT_MEM);
  assign misaligned = access & (ALU_ResultM[1:0] != 2'b00);
  assign issue      = access & ~misaligned;
  assign fault_now  = (in_idle & misaligned) | abort;

  dmem_hs_fsm #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .dmem_ready (dmem_ready),
    .in_idle    (in_idle),
    .req        (dmem_req),
    .stall      (fsm_stall),
    .complete   (complete),
    .abort      (abort)
  );

  assign StallM     = fsm_stall;
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = {ALU_ResultM[DATA_W-1:2], 2'b00};
  assign dmem_wdata = WriteDataM;

  // Stalled cycles retire a bubble; the held M inputs retire once, on completion or fault.
  always_ff @(posedge clk) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      mem_fault   <= 1'b0;
    end else begin
      if (fsm_stall) begin
        RegWriteW   <= 1'b0;
        ResultSrcW  <= 1'b0;
        RD_W        <= '0;
        PCPlus4W    <= '0;
        ALU_ResultW <= '0;
        ReadDataW   <= '0;
      end else begin
        RegWriteW   <= RegWriteM & ~fault_now;
        ResultSrcW  <= ResultSrcM;
        RD_W        <= RD_M;
        PCPlus4W    <= PCPlus4M;
        ALU_ResultW <= ALU_ResultM;
        ReadDataW   <= (complete && ResultSrcM != RESULT_ALU) ? dmem_rdata : '0;
      end
      if (fault_now) begin
        mem_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage_hs.sv
// tb/tb_memory_stage_hs.sv - self-checking bench for memory_stage_hs against a transaction-level model
module tb_memory_stage_hs;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0;
  logic [4:0]  RD_M = '0;
  logic [31:0] PCPlus4M = '0, ALU_ResultM = '0, WriteDataM = '0;
  logic        StallM, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ready = 1'b0;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
  logic        mem_fault;

  memory_stage_hs #(.DATA_W(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic        exp_rw, exp_rs, exp_fault;
  logic [4:0]  exp_rd;
  logic [31:0] exp_pc, exp_alu, exp_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_bubble();
    exp_rw = 0; exp_rs = 0; exp_rd = '0; exp_pc = '0; exp_alu = '0; exp_rdata = '0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("StallM", StallM, exp_stall);
      chk("dmem_req", dmem_req, exp_req);
      if (exp_req) begin
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_we", dmem_we, exp_we);
        chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
      chk("RegWriteW", RegWriteW, exp_rw);
      chk("ResultSrcW", ResultSrcW, exp_rs);
      chk("RD_W", RD_W, exp_rd);
      chk("PCPlus4W", PCPlus4W, exp_pc);
      chk("ALU_ResultW", ALU_ResultW, exp_alu);
      chk("ReadDataW", ReadDataW, exp_rdata);
      chk("mem_fault", mem_fault, exp_fault);
    end
  end

  // Model: an aligned access stalls min(lat,T) cycles, then completes (lat<=T) or aborts.
  task automatic run_instr(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                           input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] rdv, input int lat, output int stalls);
    bit acc, mis, ab;
    int last;
    acc  = mw | rs;
    mis  = acc && (alu[1:0] != 2'b00);
    last = (acc && !mis) ? ((lat < T) ? lat : T) : 0;
    ab   = acc && !mis && (lat > T);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    PCPlus4M = pc; ALU_ResultM = alu; WriteDataM = wd;
    stalls = 0;
    for (int k = 0; k <= last; k++) begin
      dmem_ready = (acc && !mis) ? (k >= lat) : 1'($urandom);
      dmem_rdata = rdv;
      exp_req   = acc && !mis;
      exp_stall = (k != last);
      exp_we    = mw;
      exp_addr  = {alu[31:2], 2'b00};
      exp_wdata = wd;
      @(negedge clk);
      if (StallM) stalls++;
      @(posedge clk);
      #1;
      if (k != last) begin
        set_bubble();
      end else begin
        exp_rw    = rw && !mis && !ab;
        exp_rs    = rs;
        exp_rd    = rd;
        exp_pc    = pc;
        exp_alu   = alu;
        exp_rdata = (acc && !mis && !ab && rs) ? rdv : 32'h0;
        if (mis || ab) exp_fault = 1'b1;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    chk_en = 1'b0;
    rst = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      chk("rst dmem_req", dmem_req, 0);
      chk("rst StallM", StallM, 0);
      @(posedge clk);
      #1;
      chk("rst RegWriteW", RegWriteW, 0);
      chk("rst RD_W/ResultSrcW", {RD_W, ResultSrcW}, 0);
      chk("rst PCPlus4W", PCPlus4W, 0);
      chk("rst ALU_ResultW", ALU_ResultW, 0);
      chk("rst ReadDataW", ReadDataW, 0);
      chk("rst mem_fault", mem_fault, 0);
    end
    rst = 1'b1;
    set_bubble();
    exp_fault = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    int s;
    int kind, lat;
    logic rw, mw, rs;
    logic [31:0] alu;

    // reset with a load pending on the M inputs
    RegWriteM = 1; ResultSrcM = 1; RD_M = 5'd5; ALU_ResultM = 32'h100;
    @(posedge clk);
    #1;
    do_reset(2);

    run_instr(1, 0, 1, 5'd5, 32'h1004, 32'h100, 32'h0, 32'hDEADBEEF, 0, s);
    chk("zw stalls", s, 0);
    chk("zw RegWriteW", RegWriteW, 1);
    chk("zw RD_W", RD_W, 5);
    chk("zw ReadDataW", ReadDataW, 32'hDEADBEEF);

    run_instr(0, 1, 0, 5'd0, 32'h1008, 32'h40, 32'h1234, $urandom, 3, s);
    chk("store stalls", s, 3);
    chk("store RegWriteW", RegWriteW, 0);

    run_instr(1, 0, 0, 5'd7, 32'h100C, 32'h55, 32'h0, $urandom, 0, s);
    chk("alu RD_W", RD_W, 7);
    chk("alu ALU_ResultW", ALU_ResultW, 32'h55);
    run_instr(1, 0, 1, 5'd9, 32'h1010, 32'h80, 32'h0, 32'hCAFE0001, 1, s);
    chk("load1 stalls", s, 1);
    chk("load1 ReadDataW", ReadDataW, 32'hCAFE0001);

    // reset while the load is waiting: nothing may retire
    RegWriteM = 1; MemWriteM = 0; ResultSrcM = 1; RD_M = 5'd11; ALU_ResultM = 32'h200;
    dmem_ready = 0;
    exp_req = 1; exp_stall = 1; exp_addr = 32'h200; exp_we = 0; exp_wdata = WriteDataM;
    repeat (2) begin
      @(negedge clk);
      @(posedge clk);
      #1;
      set_bubble();
    end
    do_reset(1);

    run_instr(1, 0, 1, 5'd3, 32'h2004, 32'h102, 32'h0, $urandom, 0, s);
    chk("mis stalls", s, 0);
    chk("mis mem_fault", mem_fault, 1);
    chk("mis RegWriteW", RegWriteW, 0);
    do_reset(1);

    run_instr(1, 0, 1, 5'd4, 32'h3004, 32'h300, 32'h0, $urandom, 100, s);
    chk("timeout stalls", s, 4);
    chk("timeout mem_fault", mem_fault, 1);
    chk("timeout RegWriteW", RegWriteW, 0);
    run_instr(1, 0, 0, 5'd2, 32'h3008, 32'h8, 32'h0, $urandom, 0, s);
    chk("post-abort req", dmem_req, 0);
    do_reset(1);

    // ready arriving exactly at the timeout compare completes normally
    run_instr(1, 0, 1, 5'd6, 32'h4004, 32'h400, 32'h0, 32'h0BADF00D, T, s);
    chk("edge stalls", s, 4);
    chk("edge mem_fault", mem_fault, 0);
    chk("edge ReadDataW", ReadDataW, 32'h0BADF00D);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      alu  = $urandom;
      if (kind != 0)
        alu[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rw  = (kind == 1) ? 1'b1 : (kind == 2) ? 1'b0 : 1'($urandom);
      mw  = (kind == 2);
      rs  = (kind == 1);
      lat = ($urandom_range(0, 5) == 0) ? $urandom_range(0, T + 3) : $urandom_range(0, 2);
      run_instr(rw, mw, rs, 5'($urandom), $urandom, alu, $urandom, $urandom, lat, s);
      if (i == 150) do_reset(1);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
